context_switch_controller: RTL and testbench

//  Sequencer feeding the register-file snapshot store: freezes the pipeline, captures all 32 GPRs + PC

---
 rtl/context_switch_controller.sv | 139 +++++++++++++
 tb/tb_context_switch_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/context_switch_controller.sv
// context_switch_controller
//   Freezes the pipeline and moves the 32-GPR + PC context between the core
//   and the snapshot store. A save captures the register image and PC and
//   strobes the store write. A restore strobes the store read, waits out the
//   store latency and replays the image into the GPR file one register per
//   cycle, then redirects the PC.
//   Optional feature macro: CTX_SKIP_X0_EN (x0 zeroed on save, not replayed
//   on restore).
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no operation, STALL/BUSY low, requests sampled
//   DRAIN     | stall asserted, waiting for PIPE_IDLE
//   SAVE_CAP  | image/PC held on MEM_IN_DATA/MEM_PC_IN, MEM_WRITE for 1 cycle
//   SAVE_WAIT | STORE_LAT cycles for the store write to complete
//   RST_READ  | MEM_READ for 1 cycle
//   RST_WAIT  | STORE_LAT cycles, then latch store image and PC
//   RST_WB    | one GPR write per cycle, ascending index
//   RST_PC    | one-cycle PC redirect to the restored PC
//   FINISH    | one-cycle DONE pulse, still stalled
module context_switch_controller #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int STORE_LAT = 6
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    SAVE_REQ,
  input  logic                    RESTORE_REQ,
  input  logic                    PIPE_IDLE,
  input  logic [NREGS*XLEN-1:0]   REG_IMAGE,
  input  logic [XLEN-1:0]         PC_CUR,
  output logic [NREGS*XLEN-1:0]   MEM_IN_DATA,
  output logic [XLEN-1:0]         MEM_PC_IN,
  output logic                    MEM_WRITE,
  output logic                    MEM_READ,
  input  logic [NREGS*XLEN-1:0]   MEM_OUT_DATA,
  input  logic [XLEN-1:0]         MEM_PC_OUT,
  output logic                    STALL,
  output logic                    RF_WE,
  output logic [4:0]              RF_WADDR,
  output logic [XLEN-1:0]         RF_WDATA,
  output logic                    PC_LOAD,
  output logic [XLEN-1:0]         PC_LOAD_VAL,
  output logic                    BUSY,
  output logic                    DONE
);

  localparam int IW = NREGS * XLEN;
  localparam int CW = (STORE_LAT > 1) ? $clog2(STORE_LAT) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(STORE_LAT - 1);
  localparam logic [4:0]    LAST_IDX = 5'(NREGS - 1);
`ifdef CTX_SKIP_X0_EN
  localparam logic [4:0]    FIRST_IDX = 5'd1;
`else
  localparam logic [4:0]    FIRST_IDX = 5'd0;
`endif

  typedef enum logic [3:0] {
    IDLE, DRAIN, SAVE_CAP, SAVE_WAIT, RST_READ, RST_WAIT, RST_WB, RST_PC, FINISH
  } state_t;

  state_t          state, next_state;
  logic            op_save;
  logic [CW-1:0]   lat_cnt;
  logic [4:0]      idx;
  logic [IW-1:0]   rst_image;
  logic [XLEN-1:0] rst_pc;

  // State register; reset aborts any operation on the next edge.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and control strobes, all decoded from the current state.
  always_comb begin
    next_state = state;
    STALL      = (state != IDLE);
    BUSY       = (state != IDLE);
    MEM_WRITE  = 1'b0;
    MEM_READ   = 1'b0;
    RF_WE      = 1'b0;
    PC_LOAD    = 1'b0;
    DONE       = 1'b0;
    case (state)
      IDLE:      if (SAVE_REQ || RESTORE_REQ) next_state = DRAIN;
      DRAIN:     if (PIPE_IDLE) next_state = op_save ? SAVE_CAP : RST_READ;
      SAVE_CAP:  begin MEM_WRITE = 1'b1; next_state = SAVE_WAIT; end
      SAVE_WAIT: if (lat_cnt == '0) next_state = FINISH;
      RST_READ:  begin MEM_READ = 1'b1; next_state = RST_WAIT; end
      RST_WAIT:  if (lat_cnt == '0) next_state = RST_WB;
      RST_WB:    begin RF_WE = 1'b1; if (idx == LAST_IDX) next_state = RST_PC; end
      RST_PC:    begin PC_LOAD = 1'b1; next_state = FINISH; end
      FINISH:    begin DONE = 1'b1; next_state = IDLE; end
      default:   next_state = IDLE;
    endcase
  end

  // Datapath: operation select, save capture, latency down-counter, restore latch, replay index.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_save     <= 1'b0;
      MEM_IN_DATA <= '0;
      MEM_PC_IN   <= '0;
      lat_cnt     <= '0;
      idx         <= '0;
      rst_image   <= '0;
      rst_pc      <= '0;
    end else begin
      if (state == IDLE && (SAVE_REQ || RESTORE_REQ))
        op_save <= SAVE_REQ;
      if (state == DRAIN && PIPE_IDLE && op_save) begin
`ifdef CTX_SKIP_X0_EN
        MEM_IN_DATA <= {REG_IMAGE[IW-1:XLEN], {XLEN{1'b0}}};
`else
        MEM_IN_DATA <= REG_IMAGE;
`endif
        MEM_PC_IN   <= PC_CUR;
      end
      if (state == SAVE_CAP || state == RST_READ)
        lat_cnt <= LAT_LOAD;
      else if ((state == SAVE_WAIT || state == RST_WAIT) && lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;
      if (state == RST_WAIT && lat_cnt == '0) begin
        rst_image <= MEM_OUT_DATA;
        rst_pc    <= MEM_PC_OUT;
        idx       <= FIRST_IDX;
      end else if (state == RST_WB) begin
        idx <= (idx == LAST_IDX) ? 5'd0 : idx + 5'd1;
      end
    end
  end

  assign RF_WADDR    = (state == RST_WB) ? idx : 5'd0;
  assign RF_WDATA    = (state == RST_WB) ? rst_image[int'(idx)*XLEN +: XLEN] : '0;
  assign PC_LOAD_VAL = (state == RST_PC) ? rst_pc : '0;

endmodule

// File: tb/tb_context_switch_controller.sv
// tb_context_switch_controller
//   Directed bench for context_switch_controller: reset, save, restore,
//   drain, collision, busy-ignore, mid-restore reset and re-trigger.
module tb_context_switch_controller;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int STORE_LAT = 6;
  localparam int IW = XLEN * NREGS;
`ifdef CTX_SKIP_X0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NWB = NREGS - FIRST;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic SAVE_REQ = 1'b0;
  logic RESTORE_REQ = 1'b0;
  logic PIPE_IDLE = 1'b1;
  logic [IW-1:0] REG_IMAGE = '0;
  logic [XLEN-1:0] PC_CUR = '0;
  logic [IW-1:0] MEM_OUT_DATA = '0;
  logic [XLEN-1:0] MEM_PC_OUT = '0;
  logic [IW-1:0] MEM_IN_DATA;
  logic [XLEN-1:0] MEM_PC_IN;
  logic MEM_WRITE, MEM_READ, STALL, RF_WE, PC_LOAD, BUSY, DONE;
  logic [4:0] RF_WADDR;
  logic [XLEN-1:0] RF_WDATA, PC_LOAD_VAL;

  context_switch_controller #(.XLEN(XLEN), .NREGS(NREGS), .STORE_LAT(STORE_LAT)) dut (
    .CLK(CLK), .RESET(RESET), .SAVE_REQ(SAVE_REQ), .RESTORE_REQ(RESTORE_REQ),
    .PIPE_IDLE(PIPE_IDLE), .REG_IMAGE(REG_IMAGE), .PC_CUR(PC_CUR),
    .MEM_IN_DATA(MEM_IN_DATA), .MEM_PC_IN(MEM_PC_IN), .MEM_WRITE(MEM_WRITE),
    .MEM_READ(MEM_READ), .MEM_OUT_DATA(MEM_OUT_DATA), .MEM_PC_OUT(MEM_PC_OUT),
    .STALL(STALL), .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
    .PC_LOAD(PC_LOAD), .PC_LOAD_VAL(PC_LOAD_VAL), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Event log, sampled on the falling edge.
  int wr_n = 0, rd_n = 0, done_n = 0, both_n = 0, pcl_n = 0, wb_n = 0;
  logic [IW-1:0] wr_img = '0;
  logic [XLEN-1:0] wr_pc = '0, pcl_val = '0;
  logic [4:0] wb_addr [256];
  logic [XLEN-1:0] wb_data [256];

  always @(negedge CLK) begin
    if (MEM_WRITE) begin wr_n++; wr_img = MEM_IN_DATA; wr_pc = MEM_PC_IN; end
    if (MEM_READ) rd_n++;
    if (MEM_READ && MEM_WRITE) both_n++;
    if (DONE) done_n++;
    if (PC_LOAD) begin pcl_n++; pcl_val = PC_LOAD_VAL; end
    if (RF_WE && wb_n < 256) begin
      wb_addr[wb_n] = RF_WADDR;
      wb_data[wb_n] = RF_WDATA;
      wb_n++;
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge CLK); #1; end
  endtask

  // Returns the number of falling edges walked until DONE was seen.
  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick(1);
      n++;
      if (DONE) break;
    end
    chk(tag, {63'd0, DONE}, 64'd1);
  endtask

  logic [IW-1:0] exp_save, exp_col;
  int n, b, w0, r0, d0, p0;

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      REG_IMAGE[32*i +: 32] = 32'(i) * 32'h11;
      MEM_OUT_DATA[32*i +: 32] = 32'hA000 + 32'(i);
    end
    exp_save = REG_IMAGE;
    PC_CUR = 32'h80;
    MEM_PC_OUT = 32'h200;

    // Reset state
    tick(3);
    chk("rst_ctrl", {57'd0, STALL, BUSY, DONE, MEM_WRITE, MEM_READ, RF_WE, PC_LOAD}, 64'd0);
    chk("rst_mem_img_zero", {63'd0, MEM_IN_DATA == '0}, 64'd1);
    chk("rst_mem_pc", {32'd0, MEM_PC_IN}, 64'd0);
    chk("rst_rf", {27'd0, RF_WADDR, RF_WDATA}, 64'd0);
    chk("rst_pcval", {32'd0, PC_LOAD_VAL}, 64'd0);
    RESET = 1'b0;
    tick(2);

    // Save, pipeline already idle; latency counted from the sampling edge inclusive
    w0 = wr_n; r0 = rd_n; d0 = done_n;
    SAVE_REQ = 1'b1;
    tick(1);
    SAVE_REQ = 1'b0;
    chk("save_busy", {62'd0, BUSY, STALL}, 64'd3);
    wait_done("save_done", 40, n);
    chk("save_latency", 64'(n + 1), 64'(STORE_LAT + 3));
    chk("save_writes", 64'(wr_n - w0), 64'd1);
    chk("save_reads", 64'(rd_n - r0), 64'd0);
    chk("save_pc_strobe", {32'd0, wr_pc}, 64'h80);
    chk("save_img_strobe", {63'd0, wr_img === exp_save}, 64'd1);
    chk("save_img_held", {63'd0, MEM_IN_DATA === exp_save}, 64'd1);
    chk("save_pc_held", {32'd0, MEM_PC_IN}, 64'h80);
    tick(1);
    chk("save_idle", {62'd0, BUSY, STALL}, 64'd0);
    chk("save_one_done", 64'(done_n - d0), 64'd1);

    // Restore
    b = wb_n; w0 = wr_n; r0 = rd_n; p0 = pcl_n;
    RESTORE_REQ = 1'b1;
    tick(1);
    RESTORE_REQ = 1'b0;
    wait_done("rst_done", 100, n);
    chk("rst_reads", 64'(rd_n - r0), 64'd1);
    chk("rst_writes", 64'(wr_n - w0), 64'd0);
    chk("rst_wb_count", 64'(wb_n - b), 64'(NWB));
    for (int k = 0; k < NWB; k++) begin
      chk("rst_wb_addr", {59'd0, wb_addr[b + k]}, 64'(FIRST + k));
      chk("rst_wb_data", {32'd0, wb_data[b + k]}, 64'(32'hA000 + FIRST + k));
    end
    chk("rst_pc_loads", 64'(pcl_n - p0), 64'd1);
    chk("rst_pc_val", {32'd0, pcl_val}, 64'h200);
    tick(1);

    // Drain: pipeline busy for 5 cycles
    w0 = wr_n;
    PIPE_IDLE = 1'b0;
    SAVE_REQ = 1'b1;
    tick(1);
    SAVE_REQ = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("drain_stall", {63'd0, STALL}, 64'd1);
      chk("drain_no_write", 64'(wr_n - w0), 64'd0);
      tick(1);
    end
    PIPE_IDLE = 1'b1;
    wait_done("drain_done", 40, n);
    chk("drain_writes", 64'(wr_n - w0), 64'd1);
    tick(1);

    // Collision: save wins; x0 visible to check masking
    REG_IMAGE[31:0] = 32'hDEAD;
    exp_col = REG_IMAGE;
    if (FIRST == 1) exp_col[31:0] = 32'h0;
    w0 = wr_n; r0 = rd_n;
    SAVE_REQ = 1'b1; RESTORE_REQ = 1'b1;
    tick(1);
    SAVE_REQ = 1'b0; RESTORE_REQ = 1'b0;
    wait_done("col_done", 40, n);
    chk("col_writes", 64'(wr_n - w0), 64'd1);
    chk("col_reads", 64'(rd_n - r0), 64'd0);
    chk("col_x0", {32'd0, MEM_IN_DATA[31:0]}, {32'd0, exp_col[31:0]});
    chk("col_img", {63'd0, MEM_IN_DATA === exp_col}, 64'd1);
    tick(1);

    // Busy ignore: restore pulsed during SAVE_WAIT
    r0 = rd_n; d0 = done_n;
    SAVE_REQ = 1'b1;
    tick(1);
    SAVE_REQ = 1'b0;
    tick(4);
    RESTORE_REQ = 1'b1;
    tick(1);
    RESTORE_REQ = 1'b0;
    wait_done("ign_done", 40, n);
    tick(20);
    chk("ign_reads", 64'(rd_n - r0), 64'd0);
    chk("ign_one_done", 64'(done_n - d0), 64'd1);
    chk("ign_idle", {63'd0, BUSY}, 64'd0);

    // Abort: reset while replaying idx 10
    b = wb_n; d0 = done_n; p0 = pcl_n;
    RESTORE_REQ = 1'b1;
    tick(1);
    RESTORE_REQ = 1'b0;
    n = 0;
    while (n < 100 && !(RF_WE && RF_WADDR == 5'd10)) begin tick(1); n++; end
    chk("abort_reach_idx10", {58'd0, RF_WE, RF_WADDR}, {58'd0, 1'b1, 5'd10});
    RESET = 1'b1;
    tick(1);
    chk("abort_ctrl", {57'd0, STALL, BUSY, DONE, MEM_WRITE, MEM_READ, RF_WE, PC_LOAD}, 64'd0);
    chk("abort_rf", {27'd0, RF_WADDR, RF_WDATA}, 64'd0);
    chk("abort_pcval", {32'd0, PC_LOAD_VAL}, 64'd0);
    RESET = 1'b0;
    tick(60);
    chk("abort_wb_count", 64'(wb_n - b), 64'(11 - FIRST));
    chk("abort_no_done", 64'(done_n - d0), 64'd0);
    chk("abort_no_pcload", 64'(pcl_n - p0), 64'd0);
    chk("abort_idle", {63'd0, BUSY}, 64'd0);

    // Re-trigger: request held high through completion
    SAVE_REQ = 1'b1;
    tick(1);
    wait_done("retrig_done1", 40, n);
    tick(1);
    chk("retrig_idle_gap", {63'd0, BUSY}, 64'd0);
    tick(1);
    chk("retrig_restart", {63'd0, BUSY}, 64'd1);
    SAVE_REQ = 1'b0;
    wait_done("retrig_done2", 40, n);
    tick(2);

    chk("never_rd_and_wr", 64'(both_n), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
